// File: rtl/switch_debounce.sv
// switch_debounce: synchronise and debounce active-low push-buttons into clean active-high levels and event pulses
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   switch_n      raw active-low switch pins, asynchronous to clk
//   pressed       debounced level, 1 = pressed
//   press_pulse   one-cycle pulse when pressed rises
//   release_pulse one-cycle pulse when pressed falls
//   long_press    one-cycle pulse after LONG_CYCLES of hold (only with SWITCH_LONG_PRESS_EN, else 0)
module switch_debounce #(
    parameter int NUM_SW          = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] switch_n,
    output logic [NUM_SW-1:0] pressed,
    output logic [NUM_SW-1:0] press_pulse,
    output logic [NUM_SW-1:0] release_pulse,
    output logic [NUM_SW-1:0] long_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
`ifdef SWITCH_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
`else
    localparam int unused_long_cycles = LONG_CYCLES;
`endif
    logic [NUM_SW-1:0] sync1, sync2;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= switch_n;
            sync2 <= sync1;
        end
    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic p, pp, rp, lp, stable, differ, hit;
        // the stable (active-low) level is simply the inverse of the registered output
        assign stable = !p;
        assign differ = sync2[i] != stable;
        assign hit    = differ && cnt == CNT_MAX;
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                cnt <= '0;
                p   <= 1'b0;
                pp  <= 1'b0;
                rp  <= 1'b0;
            end else begin
                cnt <= (!differ || hit) ? '0 : cnt + 1'b1;
                p   <= hit ? !sync2[i] : p;
                pp  <= hit && !sync2[i];
                rp  <= hit && sync2[i];
            end
`ifdef SWITCH_LONG_PRESS_EN
        logic [HW-1:0] hcnt;
        // saturating hold counter; the pulse fires on the step into HOLD_MAX only
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                hcnt <= '0;
                lp   <= 1'b0;
            end else begin
                hcnt <= !p ? '0 : (hcnt == HOLD_MAX) ? hcnt : hcnt + 1'b1;
                lp   <= p && hcnt == HOLD_FIRE;
            end
`else
        assign lp = 1'b0;
`endif
        assign pressed[i]       = p;
        assign press_pulse[i]   = pp;
        assign release_pulse[i] = rp;
        assign long_press[i]    = lp;
    end
endmodule
